vend_user_ctrl: RTL and testbench



---
 rtl/vend_pkg.sv | 44 ++++
 rtl/vend_idle_timer.sv | 42 ++++
 rtl/vend_user_ctrl.sv | 212 +++++++++++++++++++++
 tb/tb_vend_user_ctrl.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the vending machine user-mode controller.
// Holds the FSM state enum, coin codes, field widths and the price rule.
package vend_pkg;

    localparam int SLOT_W        = 7;
    localparam int COUNT_W       = 4;
    localparam int CREDIT_W      = 5;
    localparam int NUM_SLOTS_DEF = 69;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_CHECK,
        ST_DISPENSE,
        ST_CHANGE
    } vend_state_e;

    localparam logic [1:0] COIN_1   = 2'b00;
    localparam logic [1:0] COIN_2   = 2'b01;
    localparam logic [1:0] COIN_5   = 2'b10;
    localparam logic [1:0] COIN_BAD = 2'b11;

    // Price is 1..4 units, keyed by the two low bits of the slot index.
    function automatic logic [CREDIT_W-1:0] slot_price(
        input logic [SLOT_W-1:0] s
    );
        return CREDIT_W'(s[1:0]) + CREDIT_W'(1);
    endfunction

    function automatic logic [CREDIT_W-1:0] coin_units(
        input logic [1:0] c
    );
        logic [CREDIT_W-1:0] u;
        u = '0;
        unique case (c)
            COIN_1:  u = CREDIT_W'(1);
            COIN_2:  u = CREDIT_W'(2);
            COIN_5:  u = CREDIT_W'(5);
            default: u = '0;
        endcase
        return u;
    endfunction

endpackage

// File: rtl/vend_idle_timer.sv
// Inactivity timer: counts enabled, uncleared cycles and strobes expire
// on the TIMEOUT_CYCLES-th one. Ports: clk, rst, clear, enable -> expire.
module vend_idle_timer #(
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            cnt_d = '0;
        end else if (enable) begin
            if (cnt_q == LAST) begin
                expire = 1'b1;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/vend_user_ctrl.sv
// User-mode purchase controller: coin credit, selection, stock/price check,
// dispense and change payout. Reads stock via stock_idx/stock_count, pulses
// stock_dec per dispense; all pulse outputs are registered, one cycle wide.
module vend_user_ctrl
    import vend_pkg::*;
#(
    parameter int NUM_SLOTS      = NUM_SLOTS_DEF,
    parameter int MAX_CREDIT     = 20,
    parameter int TIMEOUT_CYCLES = 2400000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                coin_valid,
    input  logic [1:0]          coin_val,
    input  logic [SLOT_W-1:0]   slot_idx,
    input  logic                select,
    input  logic                cancel,
    output logic [SLOT_W-1:0]   stock_idx,
    input  logic [COUNT_W-1:0]  stock_count,
    output logic                stock_dec,
    output logic [CREDIT_W-1:0] credit,
    output logic                dispense,
    output logic [SLOT_W-1:0]   dispense_idx,
    output logic                change_out,
    output logic                coin_reject,
    output logic                err_empty,
    output logic                err_funds,
    output logic                busy
);

    localparam logic [CREDIT_W:0] MAX_CREDIT_W = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [SLOT_W:0]   NUM_SLOTS_W  = (SLOT_W + 1)'(NUM_SLOTS);

    vend_state_e         state_q, state_d;
    logic [CREDIT_W-1:0] credit_q, credit_d;
    logic [SLOT_W-1:0]   stock_idx_q, stock_idx_d;
    logic [SLOT_W-1:0]   dispense_idx_q, dispense_idx_d;
    logic                dispense_q, dispense_d;
    logic                stock_dec_q, stock_dec_d;
    logic                change_out_q, change_out_d;
    logic                coin_reject_q, coin_reject_d;
    logic                err_empty_q, err_empty_d;
    logic                err_funds_q, err_funds_d;
    logic                busy_q, busy_d;

    logic                timer_clear;
    logic                timer_en;
    logic                timer_expire;
    logic [CREDIT_W:0]   coin_sum;
    logic                coin_fits;
    logic [CREDIT_W-1:0] price;
    logic                slot_bad;
    logic                refund;

    assign coin_sum  = {1'b0, credit_q} + {1'b0, coin_units(coin_val)};
    assign coin_fits = (coin_val != COIN_BAD) && (coin_sum <= MAX_CREDIT_W);
    assign price     = slot_price(stock_idx_q);
    assign slot_bad  = ({1'b0, stock_idx_q} >= NUM_SLOTS_W)
                    || (stock_count == '0);

    // Timer is held clear outside CREDIT, so entering CREDIT starts at zero.
    assign timer_en    = (state_q == ST_CREDIT);
    assign timer_clear = !timer_en || coin_valid || select || cancel;

    vend_idle_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clear (timer_clear),
        .enable(timer_en),
        .expire(timer_expire)
    );

    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        stock_idx_d    = stock_idx_q;
        dispense_idx_d = dispense_idx_q;
        dispense_d     = 1'b0;
        stock_dec_d    = 1'b0;
        change_out_d   = 1'b0;
        coin_reject_d  = 1'b0;
        err_empty_d    = 1'b0;
        err_funds_d    = 1'b0;
        refund         = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (coin_valid) begin
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                        state_d  = ST_CREDIT;
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end
                if (select) begin
                    err_funds_d = 1'b1;
                end
            end
            ST_CREDIT: begin
                if (cancel) begin
                    coin_reject_d = coin_valid;
                    refund        = 1'b1;
                end else if (coin_valid) begin
                    // A coin in the same cycle as select wins; select drops.
                    if (coin_fits) begin
                        credit_d = coin_sum[CREDIT_W-1:0];
                    end else begin
                        coin_reject_d = 1'b1;
                    end
                end else if (select) begin
                    stock_idx_d = slot_idx;
                    state_d     = ST_CHECK;
                end else if (timer_expire) begin
                    refund = 1'b1;
                end
            end
            ST_CHECK: begin
                coin_reject_d = coin_valid;
                if (slot_bad) begin
                    err_empty_d = 1'b1;
                    state_d     = ST_CREDIT;
                end else if (credit_q < price) begin
                    err_funds_d = 1'b1;
                    state_d     = ST_CREDIT;
                end else begin
                    // Outputs are registered, so the dispense pulse and the
                    // price deduction are staged here to land in DISPENSE.
                    dispense_d     = 1'b1;
                    stock_dec_d    = 1'b1;
                    dispense_idx_d = stock_idx_q;
                    credit_d       = credit_q - price;
                    state_d        = ST_DISPENSE;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                refund        = 1'b1;
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
                if (credit_q == '0) begin
                    state_d = ST_IDLE;
                end else if (!change_out_q) begin
                    change_out_d = 1'b1;
                    credit_d     = credit_q - CREDIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Entering CHANGE pays the first unit immediately; CHANGE then
        // alternates low/high until credit is exhausted.
        if (refund) begin
            if (credit_q != '0) begin
                state_d      = ST_CHANGE;
                change_out_d = 1'b1;
                credit_d     = credit_q - CREDIT_W'(1);
            end else begin
                state_d = ST_IDLE;
            end
        end

        busy_d = (state_d == ST_CHECK)
              || (state_d == ST_DISPENSE)
              || (state_d == ST_CHANGE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            stock_idx_q    <= '0;
            dispense_idx_q <= '0;
            dispense_q     <= 1'b0;
            stock_dec_q    <= 1'b0;
            change_out_q   <= 1'b0;
            coin_reject_q  <= 1'b0;
            err_empty_q    <= 1'b0;
            err_funds_q    <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            stock_idx_q    <= stock_idx_d;
            dispense_idx_q <= dispense_idx_d;
            dispense_q     <= dispense_d;
            stock_dec_q    <= stock_dec_d;
            change_out_q   <= change_out_d;
            coin_reject_q  <= coin_reject_d;
            err_empty_q    <= err_empty_d;
            err_funds_q    <= err_funds_d;
            busy_q         <= busy_d;
        end
    end

    assign stock_idx    = stock_idx_q;
    assign stock_dec    = stock_dec_q;
    assign credit       = credit_q;
    assign dispense     = dispense_q;
    assign dispense_idx = dispense_idx_q;
    assign change_out   = change_out_q;
    assign coin_reject  = coin_reject_q;
    assign err_empty    = err_empty_q;
    assign err_funds    = err_funds_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_vend_user_ctrl.sv
// Directed bench for vend_user_ctrl with a reduced inactivity timeout.
// Drives a small stock table and checks pulses, credit and latencies.
module tb_vend_user_ctrl;

    logic       clk;
    logic       rst;
    logic       coin_valid;
    logic [1:0] coin_val;
    logic [6:0] slot_idx;
    logic       select;
    logic       cancel;
    logic [6:0] stock_idx;
    logic [3:0] stock_count;
    logic       stock_dec;
    logic [4:0] credit;
    logic       dispense;
    logic [6:0] dispense_idx;
    logic       change_out;
    logic       coin_reject;
    logic       err_empty;
    logic       err_funds;
    logic       busy;

    logic [3:0] stock_mem [128];

    int n_checks = 0;
    int n_fail   = 0;
    int n_change = 0;
    int n_disp   = 0;
    int n_dec    = 0;

    vend_user_ctrl #(
        .NUM_SLOTS     (69),
        .MAX_CREDIT    (20),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .coin_valid  (coin_valid),
        .coin_val    (coin_val),
        .slot_idx    (slot_idx),
        .select      (select),
        .cancel      (cancel),
        .stock_idx   (stock_idx),
        .stock_count (stock_count),
        .stock_dec   (stock_dec),
        .credit      (credit),
        .dispense    (dispense),
        .dispense_idx(dispense_idx),
        .change_out  (change_out),
        .coin_reject (coin_reject),
        .err_empty   (err_empty),
        .err_funds   (err_funds),
        .busy        (busy)
    );

    assign stock_count = stock_mem[stock_idx];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (change_out) n_change++;
        if (dispense)   n_disp++;
        if (stock_dec)  n_dec++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic coin(input logic [1:0] code);
        coin_valid = 1'b1;
        coin_val   = code;
        tick();
        coin_valid = 1'b0;
        coin_val   = 2'b00;
    endtask

    task automatic pick(input logic [6:0] s);
        slot_idx = s;
        select   = 1'b1;
        tick();
        select   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        int c0;
        int d0;

        for (int i = 0; i < 128; i++) stock_mem[i] = 4'd9;
        stock_mem[5] = 4'd0;
        rst        = 1'b1;
        coin_valid = 1'b0;
        coin_val   = 2'b00;
        slot_idx   = 7'd0;
        select     = 1'b0;
        cancel     = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        chk("rst_credit", 32'(credit), 0);
        chk("rst_pulses", 32'({dispense, stock_dec, change_out, coin_reject,
                               err_empty, err_funds, busy}), 0);
        chk("rst_stock_idx", 32'(stock_idx), 0);
        chk("rst_dispense_idx", 32'(dispense_idx), 0);

        pick(7'd0);
        chk("idle_select_err_funds", 32'(err_funds), 1);
        chk("idle_select_busy", 32'(busy), 0);
        tick();
        chk("idle_err_funds_width", 32'(err_funds), 0);

        // Buy slot 3 (price 4) with 5 units.
        coin(2'b10);
        chk("t1_credit5", 32'(credit), 5);
        pick(7'd3);
        chk("t1_check_busy", 32'(busy), 1);
        chk("t1_check_idx", 32'(stock_idx), 3);
        chk("t1_no_early_disp", 32'(dispense), 0);
        tick();
        chk("t1_dispense", 32'(dispense), 1);
        chk("t1_stock_dec", 32'(stock_dec), 1);
        chk("t1_dispense_idx", 32'(dispense_idx), 3);
        chk("t1_credit_after", 32'(credit), 1);
        chk("t1_hold_idx", 32'(stock_idx), 3);
        tick();
        chk("t1_change", 32'(change_out), 1);
        chk("t1_disp_width", 32'(dispense), 0);
        chk("t1_credit0", 32'(credit), 0);
        tick();
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_change_count", 32'(n_change), 1);
        chk("t1_dec_count", 32'(n_dec), 1);

        // Insufficient funds, then empty slot.
        coin(2'b00);
        chk("t2_credit1", 32'(credit), 1);
        pick(7'd2);
        chk("t2_no_early_err", 32'(err_funds), 0);
        tick();
        chk("t2_err_funds", 32'(err_funds), 1);
        chk("t2_credit_kept", 32'(credit), 1);
        chk("t2_busy", 32'(busy), 0);
        tick();
        chk("t2_err_width", 32'(err_funds), 0);
        pick(7'd5);
        tick();
        chk("t2_err_empty", 32'(err_empty), 1);
        chk("t2_empty_not_funds", 32'(err_funds), 0);
        chk("t2_credit_kept2", 32'(credit), 1);

        // Fill to 18, then overflow and invalid coin.
        coin(2'b10);
        coin(2'b10);
        coin(2'b10);
        coin(2'b01);
        chk("t3_credit18", 32'(credit), 18);
        coin(2'b10);
        chk("t3_overflow_reject", 32'(coin_reject), 1);
        chk("t3_overflow_credit", 32'(credit), 18);
        coin(2'b11);
        chk("t3_bad_reject", 32'(coin_reject), 1);
        chk("t3_bad_credit", 32'(credit), 18);
        tick();
        chk("t3_reject_width", 32'(coin_reject), 0);
        c0 = n_change;
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t3_refund_first", 32'(change_out), 1);
        chk("t3_refund_credit", 32'(credit), 17);
        w = 0;
        while (busy === 1'b1 && w < 100) begin
            tick();
            w++;
        end
        chk("t3_refund_cycles", 32'(w), 35);
        chk("t3_refund_pulses", 32'(n_change - c0), 18);
        chk("t3_refund_credit0", 32'(credit), 0);

        // Cancel + select + coin at credit 7.
        coin(2'b10);
        coin(2'b01);
        chk("t4_credit7", 32'(credit), 7);
        d0 = n_disp;
        cancel     = 1'b1;
        select     = 1'b1;
        slot_idx   = 7'd3;
        coin_valid = 1'b1;
        coin_val   = 2'b00;
        tick();
        cancel     = 1'b0;
        select     = 1'b0;
        coin_valid = 1'b0;
        chk("t4_coin_reject", 32'(coin_reject), 1);
        chk("t4_select_ignored", 32'(stock_idx), 5);
        chk("t4_change_t0", 32'(change_out), 1);
        chk("t4_credit_t0", 32'(credit), 6);
        for (int t = 1; t <= 12; t++) begin
            tick();
            chk("t4_change_alt", 32'(change_out), (t % 2 == 0) ? 1 : 0);
            chk("t4_credit_alt", 32'(credit), 6 - t / 2);
        end
        tick();
        chk("t4_done_busy", 32'(busy), 0);
        chk("t4_done_change", 32'(change_out), 0);
        chk("t4_no_dispense", 32'(n_disp - d0), 0);

        // Inactivity timeout at credit 3.
        coin(2'b00);
        coin(2'b01);
        chk("t5_credit3", 32'(credit), 3);
        c0 = n_change;
        w = 0;
        while (change_out !== 1'b1 && w < 300) begin
            tick();
            w++;
        end
        chk("t5_timeout_latency", 32'(w), 100);
        chk("t5_credit2", 32'(credit), 2);
        w = 0;
        while (busy === 1'b1 && w < 50) begin
            tick();
            w++;
        end
        chk("t5_refund_cycles", 32'(w), 5);
        chk("t5_refund_pulses", 32'(n_change - c0), 3);

        // Out-of-range slot.
        coin(2'b00);
        pick(7'd70);
        tick();
        chk("t5_slot70_empty", 32'(err_empty), 1);
        chk("t5_slot70_credit", 32'(credit), 1);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        tick();
        chk("t5_idle_after", 32'(busy), 0);

        // Reset during CHANGE.
        coin(2'b01);
        coin(2'b01);
        chk("t6_credit4", 32'(credit), 4);
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("t6_first_change", 32'(change_out), 1);
        tick();
        chk("t6_credit3", 32'(credit), 3);
        rst = 1'b1;
        tick();
        chk("t6_rst_credit", 32'(credit), 0);
        chk("t6_rst_pulses", 32'({dispense, stock_dec, change_out, coin_reject,
                                  err_empty, err_funds, busy}), 0);
        chk("t6_rst_stock_idx", 32'(stock_idx), 0);
        rst = 1'b0;
        c0 = n_change;
        d0 = n_dec;
        repeat (5) tick();
        chk("t6_no_more_change", 32'(n_change - c0), 0);
        chk("t6_no_dec", 32'(n_dec - d0), 0);
        pick(7'd1);
        chk("t6_idle_err_funds", 32'(err_funds), 1);
        chk("total_dispense", 32'(n_disp), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
